// File: rtl/bar_height_engine.sv
// ---------------------------------------------------------------------------
// bar_height_engine
//
// Per-frame bar-height producer for the audio visualizer. Per-band audio
// magnitudes arrive over a valid/ready handshake. The peak scaled height of
// each band is tracked for the current frame. On each frame boundary the
// peaks are moved into the displayed heights, one band per cycle. All
// top-of-bar Y coordinates are then committed in a single edge, so the
// colour mapper never sees a half-updated set of bars.
//
// Optional feature macro: BAR_PEAK_HOLD_EN
//   Defined   : displayed height = max(new peak, previous height - DECAY),
//               so bars fall slowly.
//   Undefined : displayed height = new peak, so bars drop immediately.
//
// Ports:
//   Clk          system clock
//   Reset        synchronous, active-high reset
//   mag_valid    a magnitude sample is offered
//   mag_ready    block can accept a sample (only while accumulating)
//   mag_band     band index of the sample (indexes >= NUM_BARS are dropped)
//   mag_value    unsigned magnitude
//   frame_start  one-cycle frame-boundary pulse
//   bar_top      packed top Y coordinates, bar i in bits [10i+9:10i]
//   frame_done   one-cycle pulse in the first cycle new bar_top is visible
//   overrun      sticky: frame_start arrived while a frame was in progress
// ---------------------------------------------------------------------------
module bar_height_engine #(
    parameter int NUM_BARS = 10,
    parameter int MAG_W    = 16,
    parameter int SHIFT    = 6,
    parameter int MAX_H    = 420,
    parameter int SCREEN_H = 480,
    parameter int DECAY    = 8
) (
    input  logic                   Clk,
    input  logic                   Reset,
    input  logic                   mag_valid,
    output logic                   mag_ready,
    input  logic [3:0]             mag_band,
    input  logic [MAG_W-1:0]       mag_value,
    input  logic                   frame_start,
    output logic [NUM_BARS*10-1:0] bar_top,
    output logic                   frame_done,
    output logic                   overrun
);

    localparam int               IDX_W    = (NUM_BARS > 1) ? $clog2(NUM_BARS) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BARS - 1);
    localparam logic [9:0]       MAX_H_H  = 10'(MAX_H);
    localparam logic [9:0]       SCR_H_H  = 10'(SCREEN_H);
    localparam logic [9:0]       DECAY_H  = 10'(DECAY);

    typedef enum logic [1:0] {
        ST_ACCUM  = 2'd0,
        ST_LATCH  = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    state_t                   state_r;
    state_t                   next_state_s;
    logic [IDX_W-1:0]         idx_r;
    logic [9:0]               acc_r    [NUM_BARS];
    logic [9:0]               disp_h_r [NUM_BARS];
    logic [NUM_BARS*10-1:0]   bar_top_r;
    logic                     frame_done_r;
    logic                     overrun_r;

    logic                     ready_s;
    logic                     accept_s;
    logic                     band_ok_s;
    logic [IDX_W-1:0]         band_idx_s;
    logic [9:0]               scaled_s;
    logic [9:0]               new_h_s;

    // Magnitude to pixel height: shift at full width, saturate, then narrow.
    function automatic logic [9:0] scale_mag(input logic [MAG_W-1:0] m);
        logic [MAG_W-1:0] sh;
        sh = m >> SHIFT;
        if (sh > MAG_W'(MAX_H)) begin
            return MAX_H_H;
        end else begin
            return 10'(sh);
        end
    endfunction

    // Peak-hold rule: the fresh peak wins unless the decayed bar is taller.
    function automatic logic [9:0] peak_hold(input logic [9:0] peak,
                                             input logic [9:0] shown);
        logic [9:0] dec;
        if (shown > DECAY_H) begin
            dec = shown - DECAY_H;
        end else begin
            dec = 10'd0;
        end
        if (peak > dec) begin
            return peak;
        end else begin
            return dec;
        end
    endfunction

    // The handshake is only open while accumulating and out of reset.
    assign ready_s    = (state_r == ST_ACCUM) && !Reset;
    assign accept_s   = mag_valid && ready_s;
    assign band_ok_s  = ({28'd0, mag_band} < 32'(NUM_BARS));
    assign band_idx_s = IDX_W'(mag_band);
    assign scaled_s   = scale_mag(mag_value);

    // Height that the band currently being latched will display.
    always_comb begin
        new_h_s = 10'd0;
`ifdef BAR_PEAK_HOLD_EN
        new_h_s = peak_hold(acc_r[idx_r], disp_h_r[idx_r]);
`else
        new_h_s = acc_r[idx_r];
`endif
    end

    // Next-state logic for the accumulate / latch / commit sequence.
    always_comb begin
        next_state_s = state_r;
        case (state_r)
            ST_ACCUM: begin
                if (frame_start) begin
                    next_state_s = ST_LATCH;
                end else begin
                    next_state_s = ST_ACCUM;
                end
            end
            ST_LATCH: begin
                if (idx_r == LAST_IDX) begin
                    next_state_s = ST_COMMIT;
                end else begin
                    next_state_s = ST_LATCH;
                end
            end
            ST_COMMIT: begin
                next_state_s = ST_ACCUM;
            end
            default: begin
                next_state_s = ST_ACCUM;
            end
        endcase
    end

    // State register and band index walked during LATCH.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_r <= ST_ACCUM;
            idx_r   <= '0;
        end else begin
            state_r <= next_state_s;
            if (state_r == ST_LATCH) begin
                idx_r <= idx_r + IDX_W'(1);
            end else begin
                idx_r <= '0;
            end
        end
    end

    // Per-band peak accumulators and displayed heights.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            for (int i = 0; i < NUM_BARS; i++) begin
                acc_r[i]    <= 10'd0;
                disp_h_r[i] <= 10'd0;
            end
        end else begin
            // A sample coinciding with frame_start lands here before LATCH
            // begins, so it belongs to the closing frame.
            if (accept_s && band_ok_s) begin
                if (scaled_s > acc_r[band_idx_s]) begin
                    acc_r[band_idx_s] <= scaled_s;
                end
            end
            if (state_r == ST_LATCH) begin
                disp_h_r[idx_r] <= new_h_s;
                acc_r[idx_r]    <= 10'd0;
            end
        end
    end

    // Registered outputs: all bar tops load in one edge to avoid tearing.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            bar_top_r    <= {NUM_BARS{SCR_H_H}};
            frame_done_r <= 1'b0;
            overrun_r    <= 1'b0;
        end else begin
            frame_done_r <= (state_r == ST_COMMIT);
            if (state_r == ST_COMMIT) begin
                for (int i = 0; i < NUM_BARS; i++) begin
                    bar_top_r[i*10 +: 10] <= SCR_H_H - disp_h_r[i];
                end
            end
            if (frame_start && (state_r != ST_ACCUM)) begin
                overrun_r <= 1'b1;
            end
        end
    end

    assign mag_ready  = ready_s;
    assign bar_top    = bar_top_r;
    assign frame_done = frame_done_r;
    assign overrun    = overrun_r;

endmodule

// File: tb/tb_bar_height_engine.sv
// ---------------------------------------------------------------------------
// Self-checking bench for bar_height_engine (default parameters). A
// frame-level model keeps per-band peaks, displayed heights and expected bar
// tops as plain integer arrays. Directed cases are followed by randomized
// frames.
// ---------------------------------------------------------------------------
module tb_bar_height_engine;

    localparam int NB = 10;

    logic          Clk = 1'b0;
    logic          Reset;
    logic          mag_valid;
    logic          mag_ready;
    logic [3:0]    mag_band;
    logic [15:0]   mag_value;
    logic          frame_start;
    logic [99:0]   bar_top;
    logic          frame_done;
    logic          overrun;

    int checks   = 0;
    int failures = 0;

    int acc_m  [NB];
    int disp_m [NB];
    int bar_m  [NB];
    int ovr_m;

    always #5 Clk = ~Clk;

    bar_height_engine dut (
        .Clk         (Clk),
        .Reset       (Reset),
        .mag_valid   (mag_valid),
        .mag_ready   (mag_ready),
        .mag_band    (mag_band),
        .mag_value   (mag_value),
        .frame_start (frame_start),
        .bar_top     (bar_top),
        .frame_done  (frame_done),
        .overrun     (overrun)
    );

    task automatic check_val(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d expected=%0d", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    function automatic int scale(input int m);
        int h;
        h = m / 64;
        return (h > 420) ? 420 : h;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NB; i++) begin
            acc_m[i]  = 0;
            disp_m[i] = 0;
            bar_m[i]  = 480;
        end
        ovr_m = 0;
    endtask

    task automatic model_sample(input int band, input int mag);
        if (band < NB && scale(mag) > acc_m[band]) acc_m[band] = scale(mag);
    endtask

    task automatic model_commit();
        for (int i = 0; i < NB; i++) begin
`ifdef BAR_PEAK_HOLD_EN
            int dec;
            dec = (disp_m[i] > 8) ? disp_m[i] - 8 : 0;
            disp_m[i] = (acc_m[i] > dec) ? acc_m[i] : dec;
`else
            disp_m[i] = acc_m[i];
`endif
            acc_m[i] = 0;
            bar_m[i] = 480 - disp_m[i];
        end
    endtask

    task automatic check_bars(input string tag);
        for (int i = 0; i < NB; i++) begin
            check_val(tag, 32'(bar_top[10*i +: 10]), 32'(bar_m[i]));
        end
    endtask

    task automatic send(input int band, input int mag);
        mag_valid = 1'b1;
        mag_band  = 4'(band);
        mag_value = 16'(mag);
        check_val("ready_accum", 32'(mag_ready), 32'd1);
        tick();
        mag_valid = 1'b0;
        model_sample(band, mag);
    endtask

    // One full frame; optionally a coincident sample and a stray frame_start
    // during LATCH.
    task automatic run_frame(input bit with_sample, input int sband,
                             input int smag, input bit poke);
        frame_start = 1'b1;
        if (with_sample) begin
            mag_valid = 1'b1;
            mag_band  = 4'(sband);
            mag_value = 16'(smag);
        end
        check_val("ready_fs", 32'(mag_ready), 32'd1);
        tick();
        frame_start = 1'b0;
        mag_valid   = 1'b0;
        if (with_sample) model_sample(sband, smag);
        for (int k = 1; k <= 11; k++) begin
            if (poke && k == 5) frame_start = 1'b1;
            check_val("done_early", 32'(frame_done), 32'd0);
            check_val("ready_busy", 32'(mag_ready), 32'd0);
            if (k == 11) check_bars("no_tear");
            tick();
            if (poke && k == 5) ovr_m = 1;
            frame_start = 1'b0;
        end
        model_commit();
        check_val("done_pulse", 32'(frame_done), 32'd1);
        check_val("ready_back", 32'(mag_ready), 32'd1);
        check_val("overrun", 32'(overrun), 32'(ovr_m));
        check_bars("bars");
        tick();
        check_val("done_single", 32'(frame_done), 32'd0);
    endtask

    initial begin
        Reset       = 1'b1;
        mag_valid   = 1'b0;
        mag_band    = 4'd0;
        mag_value   = 16'd0;
        frame_start = 1'b0;
        model_reset();
        tick();
        tick();
        check_val("ready_in_reset", 32'(mag_ready), 32'd0);
        Reset = 1'b0;
        repeat (5) tick();
        check_bars("reset_bars");
        check_val("reset_ready", 32'(mag_ready), 32'd1);
        check_val("reset_done", 32'(frame_done), 32'd0);
        check_val("reset_overrun", 32'(overrun), 32'd0);

        // Single band, height 100.
        send(3, 6400);
        run_frame(1'b0, 0, 0, 1'b0);
        check_val("bar3_380", 32'(bar_top[39:30]), 32'd380);

        // Empty frames: bar 3 decays (hold) or drops at once.
        repeat (13) run_frame(1'b0, 0, 0, 1'b0);
        check_val("bar3_empty", 32'(bar_top[39:30]), 32'd480);

        // Peak within a frame, saturation, out-of-range band, coincident sample.
        send(5, 3200);
        send(5, 12800);
        send(5, 640);
        send(0, 65535);
        send(12, 40000);
        run_frame(1'b1, 2, 5000, 1'b0);
        check_val("bar5_280", 32'(bar_top[59:50]), 32'd280);
        check_val("bar0_60", 32'(bar_top[9:0]), 32'd60);
        check_val("bar2_402", 32'(bar_top[29:20]), 32'd402);

        // Stray frame_start during LATCH.
        send(7, 9000);
        run_frame(1'b0, 0, 0, 1'b1);
        check_val("overrun_sticky", 32'(overrun), 32'd1);

        // Randomized frames.
        for (int f = 0; f < 20; f++) begin
            int n;
            n = int'($urandom_range(0, 8));
            for (int s = 0; s < n; s++) begin
                send(int'($urandom_range(0, 15)), int'($urandom_range(0, 65535)));
            end
            run_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 15)),
                      int'($urandom_range(0, 65535)), 1'($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of LATCH aborts the frame.
        send(4, 20000);
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        repeat (3) tick();
        Reset = 1'b1;
        tick();
        check_val("ready_mid_reset", 32'(mag_ready), 32'd0);
        Reset = 1'b0;
        model_reset();
        for (int k = 0; k < 15; k++) begin
            check_val("no_done_abort", 32'(frame_done), 32'd0);
            tick();
        end
        check_bars("abort_bars");
        check_val("abort_ready", 32'(mag_ready), 32'd1);
        check_val("abort_overrun", 32'(overrun), 32'd0);

        // Normal operation resumes after the abort.
        send(8, 30000);
        run_frame(1'b0, 0, 0, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
